// File: rtl/calc_scan_sequencer.sv
// calc_scan_sequencer
//   Frame sequencer for the serial ZSSD disparity datapath. A start pulse walks
//   every valid anchor (raster order, x inner) and every candidate disparity d.
//   For each (anchor, d) it issues the WIN*WIN window addresses into the f and g
//   RAMs and strobes the accumulators and the comparator. It then returns one
//   best disparity per anchor over a valid/ready handshake. done pulses once,
//   after the last result of the frame has been accepted.
// Ports
//   clk, reset             : clock and asynchronous active-low reset
//   start, abort           : begin a frame (only from IDLE) / abandon it (wins over start)
//   address_f, address_g   : f/g RAM read addresses (RAMs have 1-cycle read latency)
//   acc_clr, acc_en        : window accumulator clear / accumulate strobes
//   comp_clr, comp_en      : comparator clear / sample strobes
//   win_end, rank          : last comparison of the anchor / disparity under test
//   dist_in                : comparator best-disparity result
//   out_valid, out_ready   : result handshake for out_dist, out_x, out_y
//   busy, done             : frame in progress / end-of-frame pulse
module calc_scan_sequencer #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 32,
    parameter int WIN   = 5,
    parameter int DMAX  = 32,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] address_f,
    output logic [AW-1:0] address_g,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          comp_clr,
    output logic          comp_en,
    output logic          win_end,
    output logic [5:0]    rank,
    input  logic [5:0]    dist_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [5:0]    out_dist,
    output logic [6:0]    out_x,
    output logic [5:0]    out_y,
    output logic          busy,
    output logic          done
);
    localparam int NSAMP = WIN * WIN;
    localparam int KW    = $clog2(NSAMP + 1);
    localparam int WW    = $clog2(WIN + 1);

    localparam logic [6:0]    X_FIRST = 7'(DMAX - 1);
    localparam logic [6:0]    X_LAST  = 7'(IMG_W - WIN);
    localparam logic [5:0]    Y_LAST  = 6'(IMG_H - WIN);
    localparam logic [5:0]    D_LAST  = 6'(DMAX - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(NSAMP - 1);
    localparam logic [WW-1:0] WX_LAST = WW'(WIN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_EVAL, S_CAPTURE, S_EMIT, S_FIN
    } state_t;

    state_t        r_state;
    logic [6:0]    r_x;
    logic [5:0]    r_y;
    logic [5:0]    r_d;
    logic [KW-1:0] r_k;
    logic [WW-1:0] r_wx, r_wy;
    logic [AW-1:0] r_addr_f, r_addr_g;
    logic          r_acc_clr, r_acc_en, r_comp_clr, r_comp_en, r_win_end;
    logic          r_out_valid, r_done;
    logic [5:0]    r_out_dist;

    logic [WW-1:0] w_wx_nx, w_wy_nx;
    logic [AW-1:0] w_addr_nx, w_addr_g_nx;

    // Window offset of the next address to issue. In CLEAR this is (0,0).
    // In ACCUM it is the successor of the current (wx,wy), so the address
    // register always holds the address for the current k.
    always_comb begin
        w_wx_nx = '0;
        w_wy_nx = '0;
        if (r_state == S_ACCUM) begin
            if (r_wx == WX_LAST) begin
                w_wx_nx = '0;
                w_wy_nx = r_wy + WW'(1);
            end else begin
                w_wx_nx = r_wx + WW'(1);
                w_wy_nx = r_wy;
            end
        end
    end

    assign w_addr_nx   = AW'((int'(r_y) + int'(w_wy_nx)) * IMG_W + int'(r_x) + int'(w_wx_nx));
    // x >= DMAX-1 >= d, so this subtraction cannot underflow.
    assign w_addr_g_nx = w_addr_nx - AW'(r_d);

    // Strobes are registered. Each transition sets the strobes for the state
    // being entered, and all strobes default to 0 on every other cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_d         <= '0;
            r_k         <= '0;
            r_wx        <= '0;
            r_wy        <= '0;
            r_addr_f    <= '0;
            r_addr_g    <= '0;
            r_acc_clr   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_comp_clr  <= 1'b0;
            r_comp_en   <= 1'b0;
            r_win_end   <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_out_dist  <= '0;
        end else begin
            r_acc_clr  <= 1'b0;
            r_acc_en   <= 1'b0;
            r_comp_clr <= 1'b0;
            r_comp_en  <= 1'b0;
            r_win_end  <= 1'b0;
            r_done     <= 1'b0;
            if (abort) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_x        <= X_FIRST;
                        r_y        <= '0;
                        r_d        <= '0;
                        r_acc_clr  <= 1'b1;
                        r_comp_clr <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                    S_CLEAR: begin
                        r_k      <= '0;
                        r_wx     <= '0;
                        r_wy     <= '0;
                        r_addr_f <= w_addr_nx;
                        r_addr_g <= w_addr_g_nx;
                        r_state  <= S_ACCUM;
                    end
                    S_ACCUM: begin
                        // RAM data lags the address by one cycle, so every
                        // cycle after k==0 (and DRAIN) accumulates.
                        r_acc_en <= 1'b1;
                        if (r_k == K_LAST) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_k      <= r_k + KW'(1);
                            r_wx     <= w_wx_nx;
                            r_wy     <= w_wy_nx;
                            r_addr_f <= w_addr_nx;
                            r_addr_g <= w_addr_g_nx;
                        end
                    end
                    S_DRAIN: begin
                        r_comp_en <= 1'b1;
                        r_win_end <= (r_d == D_LAST);
                        r_state   <= S_EVAL;
                    end
                    S_EVAL: begin
                        if (r_d == D_LAST) begin
                            r_state <= S_CAPTURE;
                        end else begin
                            r_d       <= r_d + 6'd1;
                            r_acc_clr <= 1'b1;
                            r_state   <= S_CLEAR;
                        end
                    end
                    S_CAPTURE: begin
                        r_out_dist  <= dist_in;
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end
                    S_EMIT: if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_x == X_LAST && r_y == Y_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            if (r_x == X_LAST) begin
                                r_x <= X_FIRST;
                                r_y <= r_y + 6'd1;
                            end else begin
                                r_x <= r_x + 7'd1;
                            end
                            r_d        <= '0;
                            r_acc_clr  <= 1'b1;
                            r_comp_clr <= 1'b1;
                            r_state    <= S_CLEAR;
                        end
                    end
                    S_FIN:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign address_f = r_addr_f;
    assign address_g = r_addr_g;
    assign acc_clr   = r_acc_clr;
    assign acc_en    = r_acc_en;
    assign comp_clr  = r_comp_clr;
    assign comp_en   = r_comp_en;
    assign win_end   = r_win_end;
    assign rank      = r_d;
    assign out_valid = r_out_valid;
    assign out_dist  = r_out_dist;
    assign out_x     = r_x;
    assign out_y     = r_y;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_calc_scan_sequencer.sv
// Directed bench for calc_scan_sequencer (IMG_W=8, IMG_H=6, WIN=3, DMAX=2).
// The bench also contains a small f/g RAM, a squared-difference accumulator and a
// comparator. Together these close the loop through dist_in. g is
// chosen with distinct horizontal neighbours and f = g shifted right by one
// column, so d=1 is always the unique best disparity.
module tb_calc_scan_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, abort, out_ready;
    logic [10:0] address_f, address_g;
    logic        acc_clr, acc_en, comp_clr, comp_en, win_end;
    logic [5:0]  rank, dist_in, out_dist, out_y;
    logic [6:0]  out_x;
    logic        out_valid, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    calc_scan_sequencer #(.IMG_W(8), .IMG_H(6), .WIN(3), .DMAX(2), .AW(11)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .address_f(address_f), .address_g(address_g),
        .acc_clr(acc_clr), .acc_en(acc_en), .comp_clr(comp_clr), .comp_en(comp_en),
        .win_end(win_end), .rank(rank), .dist_in(dist_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
        .out_x(out_x), .out_y(out_y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // datapath model
    logic [15:0] fmem [64];
    logic [15:0] gmem [64];
    logic [15:0] fdata, gdata;
    logic [31:0] acc, best;

    initial begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                gmem[r*8+c] = 16'(c*c*7 + r*3);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                fmem[r*8+c] = (c == 0) ? 16'd0 : gmem[r*8+c-1];
    end

    always @(posedge clk) begin : dp
        int df;
        fdata <= fmem[address_f[5:0]];
        gdata <= gmem[address_g[5:0]];
        df = int'(fdata) - int'(gdata);
        if (acc_clr)     acc <= 32'd0;
        else if (acc_en) acc <= acc + 32'(df * df);
        if (comp_clr) begin
            best    <= '1;
            dist_in <= 6'd0;
        end else if (comp_en && acc < best) begin
            best    <= acc;
            dist_in <= rank;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_f [9] = '{1, 2, 3, 9, 10, 11, 17, 18, 19};

    initial begin
        int n_acc, last_acc, cyc, clr_cnt, cap, comp_cnt, excl_bad, bad, n, t;
        logic [6:0] sx;
        logic [5:0] sy, sd;
        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        dist_in = 6'd0;

        // reset state
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_strobes", {acc_clr, acc_en, comp_clr, comp_en, win_end, done}, 0);
        chk("rst_addr", {address_f, address_g}, 0);
        chk("rst_xyd", {out_x, out_y, rank, out_dist}, 0);
        #3 reset = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // full frame, out_ready held high
        n_acc = 0; last_acc = -1; cyc = 0; clr_cnt = 0; cap = -1; comp_cnt = 0; excl_bad = 0;
        start = 1'b1; step(); start = 1'b0;
        chk("start_busy", busy, 1);
        while (n_acc < 20 && cyc < 1000) begin
            if (acc_clr) clr_cnt++;
            if (cap >= 0 && cap < 10) begin
                if (cap < 9) begin
                    chk("addr_f", address_f, exp_f[cap]);
                    chk("addr_g", address_g, exp_f[cap] - 1);
                end
                chk("acc_en", acc_en, (cap != 0));
                cap++;
            end
            if (acc_clr && clr_cnt == 2) cap = 0;
            if (comp_en) begin
                chk("rank", rank, comp_cnt % 2);
                chk("win_end", win_end, (comp_cnt % 2) == 1);
                comp_cnt++;
            end
            if ((int'(acc_clr | comp_clr) + int'(acc_en) + int'(comp_en | win_end)) > 1 ||
                (comp_clr && !acc_clr) || (win_end && !comp_en))
                excl_bad++;
            if (out_valid) begin
                chk("out_x", out_x, 1 + n_acc % 5);
                chk("out_y", out_y, n_acc / 5);
                chk("out_dist", out_dist, 1);
                if (n_acc > 0) chk("spacing", cyc - last_acc, 26);
                last_acc = cyc;
                n_acc++;
            end
            cyc++;
            step();
        end
        chk("n_results", n_acc, 20);
        chk("done_pulse", done, 1);
        chk("busy_fin", busy, 1);
        step();
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
        chk("excl", excl_bad, 0);
        chk("n_eval", comp_cnt, 40);

        // back-pressure in EMIT
        out_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin step(); n++; end
        chk("bp_valid", out_valid, 1);
        chk("bp_first", {out_x, out_y, out_dist}, {7'd1, 6'd0, 6'd1});
        sx = out_x; sy = out_y; sd = out_dist; bad = 0;
        repeat (10) begin
            step();
            if (!out_valid || out_x != sx || out_y != sy || out_dist != sd ||
                acc_clr || acc_en || comp_clr || comp_en || win_end || done)
                bad++;
        end
        chk("bp_hold", bad, 0);
        out_ready = 1'b1;
        step();
        chk("bp_rel_valid", out_valid, 0);
        chk("bp_rel_clr", {acc_clr, comp_clr}, 2'b11);
        chk("bp_rel_x", out_x, 2);

        // abort inside ACCUM of the third anchor
        n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        chk("ab_x2", out_x, 2);
        step();
        n = 0;
        while (!acc_en && n < 20) begin step(); n++; end
        chk("ab_in_accum", {acc_en, out_x}, {1'b1, 7'd3});
        abort = 1'b1; step(); abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_outs", {out_valid, acc_clr, acc_en, comp_clr, comp_en, win_end, done}, 0);
        bad = 0;
        repeat (30) begin step(); if (done || busy) bad++; end
        chk("ab_quiet", bad, 0);

        // restart, then start pulse while busy is ignored
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        chk("rs_xy", {out_x, out_y}, {7'd1, 6'd0});
        t = 0;
        repeat (5) begin step(); t++; end
        start = 1'b1; step(); t++; start = 1'b0;
        while (!out_valid && t < 100) begin step(); t++; end
        chk("ign_x", out_x, 2);
        chk("ign_gap", t, 26);

        // async reset in EVAL of d=1
        step();
        n = 0;
        while (!(comp_en && win_end) && n < 100) begin step(); n++; end
        chk("ev_found", {comp_en, win_end, rank}, {1'b1, 1'b1, 6'd1});
        #2 reset = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_strobes", {acc_clr, acc_en, comp_clr, comp_en, win_end, out_valid, done}, 0);
        chk("ar_regs", {address_f, rank, out_dist, out_x, out_y}, 0);
        #10 reset = 1'b1;
        bad = 0;
        repeat (5) begin step(); if (done || busy) bad++; end
        chk("ar_after", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
